// File: rtl/atomrvcore_pkg.sv
// Shared types and constants for the atomrvcore load/store unit.
// Holds the LSU state encoding and RV32I memory funct3 codes.
package atomrvcore_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LD_WAIT,
        RMW_WAIT,
        RMW_WR
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    function automatic logic is_word(input logic [2:0] f3);
        return f3[1:0] == 2'b10;
    endfunction

endpackage

// File: rtl/atomrvcore_lsu_if.sv
// Execute-stage request, DCCM port and writeback return of the LSU.
// The slave modport is the LSU; master is the pipeline/memory side.
interface atomrvcore_lsu_if #(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
);
    logic                        req_valid_i;
    logic                        req_we_i;
    logic [2:0]                  req_funct3_i;
    logic [DATAWIDTH-1:0]        req_addr_i;
    logic [DATAWIDTH-1:0]        req_wdata_i;
    logic [REG_ADRESS_WIDTH-1:0] req_rd_i;
    logic                        req_ready_o;
    logic                        stall_o;
    logic [DATAWIDTH-1:0]        dmem_addr_o;
    logic                        dmem_re_o;
    logic                        dmem_we_o;
    logic [DATAWIDTH-1:0]        dmem_wdata_o;
    logic [DATAWIDTH-1:0]        dmem_rdata_i;
    logic                        ld_valid_o;
    logic [DATAWIDTH-1:0]        ld_data_o;
    logic [REG_ADRESS_WIDTH-1:0] ld_rd_o;
    logic                        misalign_o;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i,
        input  req_addr_i, req_wdata_i, req_rd_i,
        input  dmem_rdata_i,
        output req_ready_o, stall_o,
        output dmem_addr_o, dmem_re_o, dmem_we_o, dmem_wdata_o,
        output ld_valid_o, ld_data_o, ld_rd_o, misalign_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i,
        output req_addr_i, req_wdata_i, req_rd_i,
        output dmem_rdata_i,
        input  req_ready_o, stall_o,
        input  dmem_addr_o, dmem_re_o, dmem_we_o, dmem_wdata_o,
        input  ld_valid_o, ld_data_o, ld_rd_o, misalign_o
    );
endinterface

// File: rtl/atomrvcore_lsu_align.sv
// Lane logic: load extract/extend, sub-word store merge and
// alignment check, all purely combinational.
module atomrvcore_lsu_align
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    input  logic [DATAWIDTH-1:0] rdata,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic [DATAWIDTH-1:0] ld_data,
    output logic [DATAWIDTH-1:0] merged,
    output logic                 misaligned
);

    logic [4:0]           sh_b;
    logic [4:0]           sh_h;
    logic [DATAWIDTH-1:0] rd_b;
    logic [DATAWIDTH-1:0] rd_h;
    logic [BYTE_W-1:0]    lane_b;
    logic [HALF_W-1:0]    lane_h;
    logic [DATAWIDTH-1:0] mask_b;
    logic [DATAWIDTH-1:0] mask_h;
    logic [DATAWIDTH-1:0] ins_b;
    logic [DATAWIDTH-1:0] ins_h;

    assign sh_b   = {addr_lo, 3'b000};
    assign sh_h   = {addr_lo[1], 4'b0000};
    assign rd_b   = rdata >> sh_b;
    assign rd_h   = rdata >> sh_h;
    assign lane_b = rd_b[BYTE_W-1:0];
    assign lane_h = rd_h[HALF_W-1:0];

    assign mask_b = {{(DATAWIDTH-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << sh_b;
    assign mask_h = {{(DATAWIDTH-HALF_W){1'b0}}, {HALF_W{1'b1}}} << sh_h;
    assign ins_b  = {{(DATAWIDTH-BYTE_W){1'b0}}, wdata[BYTE_W-1:0]} << sh_b;
    assign ins_h  = {{(DATAWIDTH-HALF_W){1'b0}}, wdata[HALF_W-1:0]} << sh_h;

    always_comb begin
        ld_data = rdata;
        case (funct3)
            F3_B:  ld_data = {{(DATAWIDTH-BYTE_W){lane_b[BYTE_W-1]}}, lane_b};
            F3_BU: ld_data = {{(DATAWIDTH-BYTE_W){1'b0}}, lane_b};
            F3_H:  ld_data = {{(DATAWIDTH-HALF_W){lane_h[HALF_W-1]}}, lane_h};
            F3_HU: ld_data = {{(DATAWIDTH-HALF_W){1'b0}}, lane_h};
            default: ld_data = rdata;
        endcase
    end

    always_comb begin
        merged = wdata;
        case (funct3[1:0])
            2'b00: merged = (rdata & ~mask_b) | ins_b;
            2'b01: merged = (rdata & ~mask_h) | ins_h;
            default: merged = wdata;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01: misaligned = addr_lo[0];
            2'b10: misaligned = |addr_lo;
            2'b11: misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/atomrvcore_lsu.sv
// Load/store unit driving the word-wide DCCM port; sub-word stores
// are done as read-modify-write and stall the pipeline meanwhile.
module atomrvcore_lsu
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    atomrvcore_lsu_if.slave bus
);

    lsu_state_e state;
    lsu_state_e state_nxt;

    logic [DATAWIDTH-1:0]        addr_q;
    logic [DATAWIDTH-1:0]        wdata_q;
    logic [DATAWIDTH-1:0]        merged_q;
    logic [2:0]                  funct3_q;
    logic [REG_ADRESS_WIDTH-1:0] rd_q;

    logic                 idle;
    logic                 accept;
    logic                 go;
    logic [2:0]           sel_f3;
    logic [1:0]           sel_lo;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic [DATAWIDTH-1:0] al_ld;
    logic [DATAWIDTH-1:0] al_merged;
    logic                 al_mis;

    assign idle   = (state == IDLE);
    assign accept = idle && bus.req_valid_i;
    assign go     = accept && !al_mis;

    assign bus.req_ready_o = idle;
    assign bus.stall_o     = !idle;

    // In IDLE the checker looks at the live request; later at the latch.
    assign sel_f3    = idle ? bus.req_funct3_i : funct3_q;
    assign sel_lo    = idle ? bus.req_addr_i[1:0] : addr_q[1:0];
    assign sel_wdata = idle ? bus.req_wdata_i : wdata_q;

    atomrvcore_lsu_align #(
        .DATAWIDTH(DATAWIDTH)
    ) u_align (
        .funct3    (sel_f3),
        .addr_lo   (sel_lo),
        .rdata     (bus.dmem_rdata_i),
        .wdata     (sel_wdata),
        .ld_data   (al_ld),
        .merged    (al_merged),
        .misaligned(al_mis)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    if (!bus.req_we_i)                  state_nxt = LD_WAIT;
                    else if (!is_word(bus.req_funct3_i)) state_nxt = RMW_WAIT;
                    else                                state_nxt = IDLE;
                end
            end
            LD_WAIT:  state_nxt = IDLE;
            RMW_WAIT: state_nxt = RMW_WR;
            RMW_WR:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.dmem_re_o    = 1'b0;
        bus.dmem_we_o    = 1'b0;
        bus.dmem_addr_o  = {addr_q[DATAWIDTH-1:2], 2'b00};
        bus.dmem_wdata_o = merged_q;
        case (state)
            IDLE: begin
                bus.dmem_addr_o  = {bus.req_addr_i[DATAWIDTH-1:2], 2'b00};
                bus.dmem_wdata_o = bus.req_wdata_i;
                if (go) begin
                    if (bus.req_we_i && is_word(bus.req_funct3_i))
                        bus.dmem_we_o = 1'b1;
                    else
                        bus.dmem_re_o = 1'b1;
                end
            end
            RMW_WR:  bus.dmem_we_o = 1'b1;
            default: ;
        endcase
        if (rst_i) begin
            bus.dmem_re_o = 1'b0;
            bus.dmem_we_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            merged_q <= '0;
        end else begin
            if (accept) begin
                addr_q   <= bus.req_addr_i;
                wdata_q  <= bus.req_wdata_i;
                funct3_q <= bus.req_funct3_i;
                rd_q     <= bus.req_rd_i;
            end
            if (state == RMW_WAIT) merged_q <= al_merged;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.ld_valid_o <= 1'b0;
            bus.ld_data_o  <= '0;
            bus.ld_rd_o    <= '0;
            bus.misalign_o <= 1'b0;
        end else begin
            bus.ld_valid_o <= (state == LD_WAIT);
            bus.misalign_o <= accept && al_mis;
            if (state == LD_WAIT) begin
                bus.ld_data_o <= al_ld;
                bus.ld_rd_o   <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_atomrvcore_lsu.sv
// Directed bench for atomrvcore_lsu with a one-cycle-latency DCCM model.
module tb_atomrvcore_lsu;
    import atomrvcore_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   we_cnt;

    logic [31:0] mem [0:63];
    logic [31:0] rdata_q;

    atomrvcore_lsu_if bus();

    atomrvcore_lsu dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dmem_rdata_i = rdata_q;

    always @(posedge clk) begin
        if (bus.dmem_re_o) rdata_q <= mem[bus.dmem_addr_o[7:2]];
        if (bus.dmem_we_o) begin
            mem[bus.dmem_addr_o[7:2]] <= bus.dmem_wdata_o;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
        bus.req_valid_i  = v;
        bus.req_we_i     = we;
        bus.req_funct3_i = f3;
        bus.req_addr_i   = a;
        bus.req_wdata_i  = d;
        bus.req_rd_i     = rd;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d);
        @(negedge clk);
        drive(1'b1, 1'b1, f3, a, d, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        if (f3[1:0] != 2'b10) repeat (2) @(negedge clk);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, output logic [31:0] data,
                           output logic [4:0] rdo, output logic timing_ok);
        logic early;
        @(negedge clk);
        drive(1'b1, 1'b0, f3, a, 32'h0, rd);
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        early = bus.ld_valid_o;
        @(negedge clk);
        data      = bus.ld_data_o;
        rdo       = bus.ld_rd_o;
        timing_ok = !early && bus.ld_valid_o;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, F3_W, 32'h4, 32'h1234, 5'd3);
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready_o);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o);
        end
        checks++;
        if ({bus.dmem_re_o, bus.dmem_we_o} !== 2'b00) begin
            errors++; $display("FAIL reset_dmem got=%b exp=00", {bus.dmem_re_o, bus.dmem_we_o});
        end
        checks++;
        if ({bus.ld_valid_o, bus.misalign_o} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses got=%b exp=00", {bus.ld_valid_o, bus.misalign_o});
        end
        checks++;
        if (bus.ld_data_o !== 32'h0 || bus.ld_rd_o !== 5'd0) begin
            errors++; $display("FAIL reset_ld got=%h/%0d exp=0/0", bus.ld_data_o, bus.ld_rd_o);
        end
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] d;
        logic [4:0]  r;
        logic        ok;
        @(negedge clk);
        drive(1'b1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd0);
        #1;
        checks++;
        if (bus.dmem_we_o !== 1'b1 || bus.dmem_re_o !== 1'b0) begin
            errors++; $display("FAIL sw_we got=%b re=%b exp=1/0", bus.dmem_we_o, bus.dmem_re_o);
        end
        checks++;
        if (bus.dmem_addr_o !== 32'h10 || bus.dmem_wdata_o !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_bus got=%h/%h exp=00000010/deadbeef", bus.dmem_addr_o, bus.dmem_wdata_o);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        do_load(F3_W, 32'h10, 5'd5, d, r, ok);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 5'd5 || ok !== 1'b1) begin
            errors++; $display("FAIL lw got=%h rd=%0d t=%b exp=deadbeef rd=5 t=1", d, r, ok);
        end
    endtask

    task automatic test_bytes;
        logic [2:0]  f3 [6];
        logic [31:0] ad [6];
        logic [31:0] ex [6];
        logic [31:0] d;
        logic [4:0]  r;
        logic        ok;
        f3 = '{F3_B, F3_BU, F3_B, F3_H, F3_HU, F3_H};
        ad = '{32'h13, 32'h13, 32'h11, 32'h12, 32'h12, 32'h10};
        ex = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
               32'hFFFF80FF, 32'h000080FF, 32'h00007F01};
        do_store(F3_W, 32'h10, 32'h80FF7F01);
        for (int i = 0; i < 6; i++) begin
            do_load(f3[i], ad[i], 5'(i + 1), d, r, ok);
            checks++;
            if (d !== ex[i] || r !== 5'(i + 1) || ok !== 1'b1) begin
                errors++;
                $display("FAIL subload_%0d got=%h rd=%0d t=%b exp=%h rd=%0d t=1", i, d, r, ok, ex[i], i + 1);
            end
        end
    endtask

    task automatic test_rmw;
        logic [31:0] d;
        logic [4:0]  r;
        logic        ok;
        do_store(F3_W, 32'h20, 32'h11223344);
        do_store(F3_W, 32'h24, 32'h12345678);
        @(negedge clk);
        drive(1'b1, 1'b1, F3_B, 32'h21, 32'h000000AA, 5'd0);
        #1;
        checks++;
        if (bus.dmem_re_o !== 1'b1 || bus.dmem_we_o !== 1'b0 || bus.dmem_addr_o !== 32'h20) begin
            errors++; $display("FAIL sb_read got re=%b we=%b a=%h exp 1/0/20", bus.dmem_re_o, bus.dmem_we_o, bus.dmem_addr_o);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, F3_W, 32'h24, 32'h55555555, 5'd0);
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b0 || bus.dmem_re_o !== 1'b0 || bus.dmem_we_o !== 1'b0) begin
            errors++; $display("FAIL sb_wait got rdy=%b re=%b we=%b exp 0/0/0", bus.req_ready_o, bus.dmem_re_o, bus.dmem_we_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b0 || bus.dmem_we_o !== 1'b1 ||
            bus.dmem_addr_o !== 32'h20 || bus.dmem_wdata_o !== 32'h1122AA44) begin
            errors++; $display("FAIL sb_write got rdy=%b we=%b a=%h d=%h exp 0/1/20/1122aa44",
                               bus.req_ready_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_wdata_o);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL sb_done got rdy=%b exp=1", bus.req_ready_o);
        end
        do_load(F3_W, 32'h24, 5'd2, d, r, ok);
        checks++;
        if (d !== 32'h12345678) begin
            errors++; $display("FAIL busy_ignored got=%h exp=12345678", d);
        end
        do_load(F3_W, 32'h20, 5'd3, d, r, ok);
        checks++;
        if (d !== 32'h1122AA44) begin
            errors++; $display("FAIL sb_result got=%h exp=1122aa44", d);
        end
        do_store(F3_H, 32'h22, 32'h0000BEEF);
        do_load(F3_W, 32'h20, 5'd4, d, r, ok);
        checks++;
        if (d !== 32'hBEEFAA44) begin
            errors++; $display("FAIL sh_result got=%h exp=beefaa44", d);
        end
    endtask

    task automatic test_misalign;
        @(negedge clk);
        drive(1'b1, 1'b0, F3_W, 32'h06, 32'h0, 5'd6);
        #1;
        checks++;
        if (bus.dmem_re_o !== 1'b0 || bus.dmem_we_o !== 1'b0) begin
            errors++; $display("FAIL lw_mis_dmem got re=%b we=%b exp 0/0", bus.dmem_re_o, bus.dmem_we_o);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        checks++;
        if (bus.misalign_o !== 1'b1 || bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL lw_mis_pulse got mis=%b rdy=%b exp 1/1", bus.misalign_o, bus.req_ready_o);
        end
        @(negedge clk);
        checks++;
        if (bus.misalign_o !== 1'b0 || bus.ld_valid_o !== 1'b0) begin
            errors++; $display("FAIL lw_mis_after got mis=%b ldv=%b exp 0/0", bus.misalign_o, bus.ld_valid_o);
        end
        drive(1'b1, 1'b1, F3_H, 32'h03, 32'h1111, 5'd0);
        #1;
        checks++;
        if (bus.dmem_we_o !== 1'b0 || bus.dmem_re_o !== 1'b0) begin
            errors++; $display("FAIL sh_mis_dmem got we=%b re=%b exp 0/0", bus.dmem_we_o, bus.dmem_re_o);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        checks++;
        if (bus.misalign_o !== 1'b1) begin
            errors++; $display("FAIL sh_mis_pulse got=%b exp=1", bus.misalign_o);
        end
    endtask

    task automatic test_reset_mid;
        int          wc;
        logic [31:0] d;
        logic [4:0]  r;
        logic        ok;
        do_store(F3_W, 32'h30, 32'hCAFEF00D);
        wc = we_cnt;
        @(negedge clk);
        drive(1'b1, 1'b1, F3_B, 32'h30, 32'h00000011, 5'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready_o !== 1'b1 || bus.dmem_we_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid got rdy=%b we=%b exp 1/0", bus.req_ready_o, bus.dmem_we_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt !== wc || bus.ld_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_after got wr=%0d ldv=%b rdy=%b exp %0d/0/1", we_cnt - wc, bus.ld_valid_o, bus.req_ready_o, 0);
        end
        do_load(F3_W, 32'h30, 5'd8, d, r, ok);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++; $display("FAIL rst_mem got=%h exp=cafef00d", d);
        end
    endtask

    task automatic test_back_to_back;
        logic        we [5];
        logic [2:0]  f3 [5];
        logic [31:0] ad [5];
        logic [31:0] wd [5];
        logic [4:0]  rd [5];
        logic        exp_stall [11];
        int          k;
        we = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        f3 = '{F3_W, F3_W, F3_W, F3_B, F3_W};
        ad = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h44};
        wd = '{32'hA5A5A5A5, 32'h01020304, 32'h0, 32'h000000FF, 32'h0};
        rd = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd9};
        exp_stall = '{0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
        k = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (bus.stall_o !== exp_stall[i]) begin
                errors++; $display("FAIL b2b_stall_%0d got=%b exp=%b", i, bus.stall_o, exp_stall[i]);
            end
            checks++;
            if (bus.ld_valid_o !== (i == 4 || i == 9)) begin
                errors++; $display("FAIL b2b_ldv_%0d got=%b", i, bus.ld_valid_o);
            end
            if (i == 4) begin
                checks++;
                if (bus.ld_data_o !== 32'hA5A5A5A5 || bus.ld_rd_o !== 5'd7) begin
                    errors++; $display("FAIL b2b_lw1 got=%h rd=%0d exp=a5a5a5a5 rd=7", bus.ld_data_o, bus.ld_rd_o);
                end
            end
            if (i == 9) begin
                checks++;
                if (bus.ld_data_o !== 32'h010203FF || bus.ld_rd_o !== 5'd9) begin
                    errors++; $display("FAIL b2b_lw2 got=%h rd=%0d exp=010203ff rd=9", bus.ld_data_o, bus.ld_rd_o);
                end
            end
            if (bus.req_ready_o && k < 5) begin
                drive(1'b1, we[k], f3[k], ad[k], wd[k], rd[k]);
                k++;
            end else begin
                drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        we_cnt  = 0;
        rdata_q = 32'h0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd0);
        test_reset;
        test_word;
        test_bytes;
        test_rmw;
        test_misalign;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
